// File: rtl/ws281x_splitter_sync.sv
// ws281x_splitter_sync: oversamples one WS281X stream, recovers 24-bit nodes and
// demultiplexes the stream onto NUM_BR branch outputs with a frame-latch Sync pulse.
// Latency: BranchOut 3 clocks from Din; Valid/Node 1 clock after the 24th sample.
// Backpressure: none, free-running; the input stream cannot be stalled.
// Optional macro WS281X_AUTOLEN_EN: auto-advance after BR_LEN non-escape nodes per branch.
// Ports: i_clock, i_reset (sync, active-high), i_din (async), o_branch_out[NUM_BR],
//        o_node[24], o_valid, o_sync, o_branch_sel[clog2(NUM_BR)], o_frame_err.
module ws281x_splitter_sync #(
    parameter int          CLK_FREQ_HZ     = 50_000_000,
    parameter int          NUM_BR          = 8,
    parameter logic [23:0] ESC_NEXT_BRANCH = 24'h010203,
    parameter int          SAMPLE_NS       = 600,
    parameter int          ADV_NS          = 1000,
    parameter int          LATCH_US        = 50,
    parameter int          SYNC_W          = 5,
    parameter int          BR_LEN          = 0
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_din,
    output logic [NUM_BR-1:0]         o_branch_out,
    output logic [23:0]               o_node,
    output logic                      o_valid,
    output logic                      o_sync,
    output logic [$clog2(NUM_BR)-1:0] o_branch_sel,
    output logic                      o_frame_err
);
    localparam longint SAMPLE_L = (longint'(SAMPLE_NS) * longint'(CLK_FREQ_HZ)) / 64'd1_000_000_000;
    localparam longint ADV_L    = (longint'(ADV_NS) * longint'(CLK_FREQ_HZ)) / 64'd1_000_000_000;
    localparam longint LATCH_L  = (longint'(LATCH_US) * longint'(CLK_FREQ_HZ)) / 64'd1_000_000;
    localparam int     TW       = $clog2(int'(LATCH_L) + 1);
    localparam int     SW       = $clog2(NUM_BR);
    localparam int     SCW      = $clog2(SYNC_W + 1);

    localparam logic [TW-1:0] C_SAMPLE   = TW'(SAMPLE_L);
    localparam logic [TW-1:0] C_ADV      = TW'(ADV_L);
    localparam logic [TW-1:0] C_LATCH    = TW'(LATCH_L);
    localparam logic [TW-1:0] C_LATCH_M1 = TW'(LATCH_L - 1);
    localparam logic [SW-1:0] C_LAST     = SW'(NUM_BR - 1);

    typedef enum logic {S_UNARMED, S_ARMED} state_t;

    state_t           r_state, w_state_next;
    logic             r_meta, r_din_s, r_din_d;
    logic [TW-1:0]    r_timer;
    logic [22:0]      r_shift;
    logic [4:0]       r_bitcnt;
    logic             r_adv_pend;
    logic [SW-1:0]    r_sel;
    logic [SCW-1:0]   r_sync_cnt;
    logic [NUM_BR-1:0] r_branch_out;
    logic [23:0]      r_node;
    logic             r_valid, r_frame_err;

    logic             w_rise, w_armed, w_latch, w_sample, w_done, w_is_esc, w_adv, w_len_hit;
    logic [23:0]      w_word;

    assign w_rise   = r_din_s & ~r_din_d;
    assign w_armed  = (r_state == S_ARMED);
    // Latch fires on the clock the timer steps onto LATCH; a rising edge that
    // same clock clears the timer instead, so the edge wins.
    assign w_latch  = w_armed && (r_timer == C_LATCH_M1) && !w_rise;
    assign w_sample = w_armed && (r_timer == C_SAMPLE);
    assign w_word   = {r_shift, r_din_s};
    assign w_done   = w_sample && (r_bitcnt == 5'd23);
    assign w_is_esc = (w_word == ESC_NEXT_BRANCH);
    // Using >= turns the advance into a deferral: it waits for din_s low if
    // the line is still high at the ADV tick.
    assign w_adv    = w_armed && r_adv_pend && (r_timer >= C_ADV) && !r_din_s;

`ifdef WS281X_AUTOLEN_EN
    localparam int NCW = (BR_LEN > 0) ? $clog2(BR_LEN + 1) : 1;
    logic [NCW-1:0] r_ncnt;

    assign w_len_hit = (BR_LEN > 0) && w_done && !w_is_esc && (r_ncnt == NCW'(BR_LEN - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset || w_latch) begin
            r_ncnt <= '0;
        end else if (w_done) begin
            if (w_is_esc || w_len_hit) r_ncnt <= '0;
            else                       r_ncnt <= r_ncnt + 1'b1;
        end
    end
`else
    assign w_len_hit = 1'b0;
`endif

    // Arming needs a full latch-length idle with the line low; the timer is
    // already saturated if Din was held high, so arm as soon as it drops.
    always_comb begin
        w_state_next = r_state;
        if (r_state == S_UNARMED && r_timer == C_LATCH && !r_din_s)
            w_state_next = S_ARMED;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_UNARMED;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_meta       <= 1'b0;
            r_din_s      <= 1'b0;
            r_din_d      <= 1'b0;
            r_timer      <= '0;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_adv_pend   <= 1'b0;
            r_sel        <= '0;
            r_sync_cnt   <= '0;
            r_branch_out <= '0;
            r_node       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_meta      <= i_din;
            r_din_s     <= r_meta;
            r_din_d     <= r_din_s;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_rise)                r_timer <= '0;
            else if (r_timer != C_LATCH) r_timer <= r_timer + 1'b1;

            if (r_sync_cnt != '0) r_sync_cnt <= r_sync_cnt - 1'b1;

            if (w_latch) begin
                r_sync_cnt  <= SCW'(SYNC_W);
                r_sel       <= '0;
                r_adv_pend  <= 1'b0;
                r_bitcnt    <= '0;
                r_frame_err <= (r_bitcnt != '0);
            end else begin
                if (w_sample) begin
                    r_shift  <= w_word[22:0];
                    r_bitcnt <= w_done ? 5'd0 : r_bitcnt + 5'd1;
                end
                if (w_done) begin
                    r_node  <= w_word;
                    r_valid <= 1'b1;
                    // On the last branch escapes are ignored, so sel saturates.
                    if ((w_is_esc || w_len_hit) && (r_sel != C_LAST))
                        r_adv_pend <= 1'b1;
                end else if (w_adv) begin
                    r_sel      <= r_sel + 1'b1;
                    r_adv_pend <= 1'b0;
                end
            end

            for (int i = 0; i < NUM_BR; i++)
                r_branch_out[i] <= r_din_s & w_armed & (r_sel == SW'(i));
        end
    end

    assign o_branch_out = r_branch_out;
    assign o_node       = r_node;
    assign o_valid      = r_valid;
    assign o_sync       = (r_sync_cnt != '0);
    assign o_branch_sel = r_sel;
    assign o_frame_err  = r_frame_err;
endmodule

// File: tb/tb_ws281x_splitter_sync.sv
// Directed bench for ws281x_splitter_sync at 50 MHz, NUM_BR=8, BR_LEN=2.
// Bits: 1 = 40 clk high / 22 low, 0 = 20 high / 42 low; inputs driven on negedge.
// Outputs are observed on negedge by a monitor that accumulates per-branch high time.
module tb_ws281x_splitter_sync;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din = 1'b0;
    logic [NB-1:0] o_branch_out;
    logic [23:0]   o_node;
    logic          o_valid, o_sync, o_frame_err;
    logic [2:0]    o_branch_sel;

    ws281x_splitter_sync #(.NUM_BR(NB), .BR_LEN(2)) dut (
        .i_clock(clk), .i_reset(rst), .i_din(din),
        .o_branch_out(o_branch_out), .o_node(o_node), .o_valid(o_valid),
        .o_sync(o_sync), .o_branch_sel(o_branch_sel), .o_frame_err(o_frame_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor
    int   bo_hi[NB];
    int   n_valid = 0, n_sync = 0, n_ferr = 0;
    int   last_valid_cyc = 0, last_bo0_rise = 0, sync_start = 0;
    logic [23:0] last_node = '0;
    logic prev_bo0 = 1'b0, prev_sync = 1'b0;

    initial for (int i = 0; i < NB; i++) bo_hi[i] = 0;

    always @(negedge clk) begin
        if (o_valid) begin
            n_valid++;
            last_node      = o_node;
            last_valid_cyc = cyc;
        end
        for (int i = 0; i < NB; i++) bo_hi[i] += int'(o_branch_out[i]);
        if (o_branch_out[0] && !prev_bo0) last_bo0_rise = cyc;
        prev_bo0 = o_branch_out[0];
        if (o_sync) n_sync++;
        if (o_sync && !prev_sync) sync_start = cyc;
        prev_sync = o_sync;
        n_ferr += int'(o_frame_err);
    end

    // Driver (all tasks start and end on a negedge)
    int last_rise = 0;

    task automatic send_bit(input logic b);
        din = 1'b1;
        last_rise = cyc;
        repeat (b ? 40 : 20) @(negedge clk);
        din = 1'b0;
        repeat (b ? 22 : 42) @(negedge clk);
    endtask

    task automatic send_node(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic int hi(input logic [23:0] w);
        int s = 0;
        for (int i = 0; i < 24; i++) s += w[i] ? 40 : 20;
        return s;
    endfunction

    int base[NB];
    int v0, s0, f0, other;
    logic [23:0] nodes6 [5];
    int exp6[NB];

    task automatic snap();
        for (int i = 0; i < NB; i++) base[i] = bo_hi[i];
        v0 = n_valid; s0 = n_sync; f0 = n_ferr;
    endtask

    initial begin
        // Reset values
        repeat (4) @(negedge clk);
        #1;
        chk("rst_branch_out", 32'(o_branch_out), 0);
        chk("rst_node", 32'(o_node), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_sync", 32'(o_sync), 0);
        chk("rst_branch_sel", 32'(o_branch_sel), 0);
        chk("rst_frame_err", 32'(o_frame_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // Din high 100 us while unarmed: nothing routed, nothing decoded
        snap();
        din = 1'b1;
        repeat (5000) @(negedge clk);
        #1;
        chk("unarmed_bo0_high", 32'(bo_hi[0] - base[0]), 0);
        chk("unarmed_valid", 32'(n_valid - v0), 0);
        @(negedge clk);
        idle(3000);

        // Single node FF0000
        snap();
        send_node(24'hFF0000);
        #1;
        chk("ff_valid_count", 32'(n_valid - v0), 1);
        chk("ff_node", 32'(last_node), 32'hFF0000);
        chk("ff_valid_latency", 32'(last_valid_cyc - last_rise), 34);
        chk("ff_bo_latency", 32'(last_bo0_rise - last_rise), 3);
        chk("ff_bo0_high", 32'(bo_hi[0] - base[0]), 32'(hi(24'hFF0000)));
        other = 0;
        for (int i = 1; i < NB; i++) other += bo_hi[i] - base[i];
        chk("ff_other_high", 32'(other), 0);
        @(negedge clk);
        idle(2600);

        // Plain, escape, plain
        snap();
        send_node(24'h123456);
        send_node(24'h010203);
        send_node(24'hABCDEF);
        #1;
        chk("esc_bo0_high", 32'(bo_hi[0] - base[0]), 32'(hi(24'h123456) + hi(24'h010203)));
        chk("esc_bo1_high", 32'(bo_hi[1] - base[1]), 32'(hi(24'hABCDEF)));
        chk("esc_branch_sel", 32'(o_branch_sel), 1);
        chk("esc_last_node", 32'(last_node), 32'hABCDEF);
        @(negedge clk);
        idle(2600);

        // Nine escapes saturate at branch 7, then latch
        for (int k = 0; k < 9; k++) send_node(24'h010203);
        #1;
        chk("sat_branch_sel", 32'(o_branch_sel), 7);
        @(negedge clk);
        snap();
        idle(2600);
        #1;
        chk("sat_sync_width", 32'(n_sync - s0), 5);
        chk("sat_sync_start", 32'(sync_start - last_rise), 2503);
        chk("sat_sel_after_latch", 32'(o_branch_sel), 0);
        @(negedge clk);

        // Partial frame of 10 bits
        snap();
        for (int k = 0; k < 10; k++) send_bit(k[0]);
        idle(2600);
        #1;
        chk("part_frame_err", 32'(n_ferr - f0), 1);
        chk("part_sync_width", 32'(n_sync - s0), 5);
        chk("part_no_valid", 32'(n_valid - v0), 0);
        @(negedge clk);
        send_node(24'h5A5A5A);
        #1;
        chk("part_next_node", 32'(last_node), 32'h5A5A5A);
        chk("part_next_valid", 32'(n_valid - v0), 1);
        @(negedge clk);
        idle(2600);

        // Five plain nodes: auto-length routing when compiled in
        nodes6[0] = 24'h111111; nodes6[1] = 24'h222222; nodes6[2] = 24'h333333;
        nodes6[3] = 24'h444444; nodes6[4] = 24'h555555;
        for (int i = 0; i < NB; i++) exp6[i] = 0;
        for (int k = 0; k < 5; k++) begin
`ifdef WS281X_AUTOLEN_EN
            exp6[k / 2] += hi(nodes6[k]);
`else
            exp6[0] += hi(nodes6[k]);
`endif
        end
        snap();
        for (int k = 0; k < 5; k++) send_node(nodes6[k]);
        #1;
        chk("len_bo0_high", 32'(bo_hi[0] - base[0]), 32'(exp6[0]));
        chk("len_bo1_high", 32'(bo_hi[1] - base[1]), 32'(exp6[1]));
        chk("len_bo2_high", 32'(bo_hi[2] - base[2]), 32'(exp6[2]));
        chk("len_valid_count", 32'(n_valid - v0), 5);
        @(negedge clk);
        idle(100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ws281x_splitter_sync.md
Name: ws281x_splitter_sync

Overview:
- Fully synchronous, parametrised successor to the WS281X splitter.
- Oversamples one WS281X serial stream on the system clock and recovers 24-bit nodes.
- Routes the stream to one of NUM_BR branch outputs, advancing on an escape node (and optionally on a node count).
- Emits a latch-time Sync pulse. Sits between the upstream pixel controller and the parallel LED strings.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency; all tick counts derive from it.
- NUM_BR, 8, number of branch outputs (2..16).
- ESC_NEXT_BRANCH, 24'h010203, node value that advances to the next branch.
- SAMPLE_NS, 600, bit sample point after rising edge (ticks = SAMPLE_NS*CLK_FREQ_HZ/1e9; 30 @50 MHz).
- ADV_NS, 1000, branch-advance point after rising edge (50 ticks).
- LATCH_US, 50, idle-low time that ends a frame (2500 ticks).
- SYNC_W, 5, Sync pulse width in clocks.
- BR_LEN, 0, nodes per branch before auto-advance (used only with the optional feature; 0 = off).

Ports:
- Clock  in  1  system clock; all state on posedge.
- Reset  in  1  synchronous, active-high reset.
- Din  in  1  asynchronous WS281X input.
- BranchOut  out  NUM_BR  demuxed stream.
- Node  out  24  last complete node, MSB-first (first received bit = bit 23).
- Valid  out  1  one-clock pulse when Node updates.
- Sync  out  1  frame-latch pulse.
- BranchSel  out  clog2(NUM_BR)  current branch index.
- FrameErr  out  1  one-clock pulse: frame ended with a partial node.

Behaviour:
- Input path: 2-FF synchroniser gives din_s; a third FF gives din_d. Rising edge = din_s & ~din_d.
- Timer: width clog2(LATCH ticks + 1). Cleared to 0 on a rising edge; otherwise increments and saturates at the LATCH tick count.
- Arming:
  - After Reset the block is UNARMED. BranchOut = 0 and no bits are decoded.
  - It becomes ARMED when the timer reaches LATCH with din_s low. That event does not emit Sync.
- Bit recovery (ARMED):
  - At timer == SAMPLE tick, din_s is shifted into a 24-bit shift register and bitcnt (0..23) increments.
  - When bitcnt wraps from 23: Node <= the shifted word and Valid pulses on the following clock. Latency is 1 clock after the 24th sample.
- Escape: a completed node equal to ESC_NEXT_BRANCH sets adv_pend. The escape node itself is forwarded to the current branch.
- Advance:
  - At timer == ADV tick with adv_pend set and din_s low: BranchSel increments and adv_pend clears.
  - If din_s is high at that tick, the advance is deferred to the first clock with din_s low, so no fragment is emitted on either branch.
  - At NUM_BR-1, BranchSel saturates and further escapes are ignored.
- Routing: BranchOut[i] = din_s & ARMED & (BranchSel == i), registered. Latency is 3 clocks from Din.
- Latch (timer reaches LATCH while ARMED):
  - Sync is high for SYNC_W clocks starting the next clock.
  - BranchSel <= 0, adv_pend <= 0, bitcnt <= 0, node counter <= 0.
  - FrameErr pulses if bitcnt != 0.
  - Saturation prevents re-firing until the next rising edge.
- Simultaneous events: a rising edge on the latch clock wins (timer clears, no Sync). A rising edge during Sync does not truncate the pulse.
- Reset values:
  - BranchOut 0, Node 0, Valid 0, Sync 0, BranchSel 0, FrameErr 0.
  - Timer 0, UNARMED.
- Reset mid-frame discards the partial node and any pending advance.

Optional Feature:
- Macro: WS281X_AUTOLEN_EN.
- Defined, with BR_LEN > 0:
  - A per-branch node counter counts completed non-escape nodes.
  - When it reaches BR_LEN it sets adv_pend (same deferral rules) and clears.
  - An escape also clears the counter.
- Undefined: no counter logic; BR_LEN is ignored and only escapes advance.

Test Plan:
- Reset, then hold Din high 100 us -> BranchOut stays 0, no Valid.
- After 60 us low, a 1-bit is 40 clk high / 22 low and a 0-bit is 20 high / 42 low. Send node 24'hFF0000 -> Valid once 1 clk after the 24th sample, Node = FF0000, waveform on BranchOut[0] only with 3-clk latency.
- Send node 0x123456, then escape 010203, then 0xABCDEF -> the first two appear on BranchOut[0], the third on BranchOut[1], BranchSel = 1.
- Send 9 escapes with NUM_BR = 8 -> BranchSel saturates at 7; then 2500 idle clocks -> Sync high for exactly 5 clks, BranchSel = 0.
- Send 10 bits, then idle -> FrameErr pulse, Sync pulse, next node decodes correctly.
- With WS281X_AUTOLEN_EN and BR_LEN = 2, send 5 plain nodes -> they land on branches 0, 0, 1, 1, 2. Without the macro -> all 5 land on branch 0.
